studio2_keypad: RTL and testbench



---
 rtl/studio2_pkg.sv | 43 ++++
 rtl/studio2_keybank.sv | 64 ++++++
 rtl/studio2_keypad.sv | 88 ++++++++
 tb/tb_studio2_keypad.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/studio2_pkg.sv
// rtl/studio2_pkg.sv - Shared constants, scan-code tables and lookup helpers for the Studio II keypad front end
package studio2_pkg;

  localparam int         NUM_KEYS    = 10;
  localparam logic [2:0] KEYSEL_PORT = 3'd2;

  typedef logic [NUM_KEYS-1:0] keymask_t;
  typedef logic [7:0]          code_tbl_t [NUM_KEYS];

  // Entry k is the PS/2 set-2 make code of hex digit k on that pad.
  localparam code_tbl_t KP1_CODES = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam code_tbl_t KP2_CODES = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                      8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } key_hit_t;

  function automatic key_hit_t lookup_code(input logic [7:0] code, input code_tbl_t tbl);
    key_hit_t hit;
    hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (code == tbl[i]) begin
        hit.valid = 1'b1;
        hit.idx   = 4'(i);
      end
    end
    return hit;
  endfunction

  // Select values 10..15 match no digit, so they read as "not pressed".
  function automatic logic key_selected(input keymask_t keys, input logic [3:0] sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sel == 4'(i)) hit = keys[i];
    end
    return hit;
  endfunction

endpackage

// File: rtl/studio2_keybank.sv
// rtl/studio2_keybank.sv - Raw key mask for one hex pad plus the optional release-stretch slot
// STUDIO2_KEY_STRETCH_EN adds a single hold slot that keeps the last released key asserted.
module studio2_keybank
  import studio2_pkg::*;
#(
  parameter int STRETCH_CYCLES = 700000,
  parameter int STRETCH_W      = 20
) (
  input  logic       clk_sys,
  input  logic       resetq,
  input  logic       key_evt,
  input  logic       key_press,
  input  logic       idx_vld,
  input  logic [3:0] key_idx,
  output keymask_t   keys
);

  keymask_t raw_q;
  keymask_t idx_bit;
  logic     upd;

  assign upd     = key_evt && idx_vld;
  assign idx_bit = keymask_t'(1) << key_idx;

  always_ff @(posedge clk_sys or negedge resetq) begin
    if (!resetq) begin
      raw_q <= '0;
    end else if (upd) begin
      raw_q <= key_press ? (raw_q | idx_bit) : (raw_q & ~idx_bit);
    end
  end

`ifdef STUDIO2_KEY_STRETCH_EN
  logic [3:0]           hold_key;
  logic [STRETCH_W-1:0] hold_cnt;
  logic                 release_down;

  // Only a release of a key that is actually down starts a hold.
  assign release_down = upd && !key_press && ((raw_q & idx_bit) != '0);

  always_ff @(posedge clk_sys or negedge resetq) begin
    if (!resetq) begin
      hold_key <= '0;
      hold_cnt <= '0;
    end else if (release_down) begin
      hold_key <= key_idx;
      hold_cnt <= STRETCH_W'(STRETCH_CYCLES);
    end else if (upd && key_press && key_idx == hold_key) begin
      hold_cnt <= '0;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - STRETCH_W'(1);
    end
  end

  assign keys = raw_q | ((hold_cnt != '0) ? (keymask_t'(1) << hold_key) : '0);
`else
  assign keys = raw_q;
`endif

  if (STRETCH_CYCLES < 0 || STRETCH_CYCLES >= 2**STRETCH_W) begin : g_bad_stretch
    $error("studio2_keybank: STRETCH_CYCLES does not fit in STRETCH_W bits");
  end

endmodule

// File: rtl/studio2_keypad.sv
// rtl/studio2_keypad.sv - PS/2 to Studio II dual hex keypad, OUT 2 key-select latch and EF3/EF4 flags
// Optional release stretch on each pad is enabled by STUDIO2_KEY_STRETCH_EN.
module studio2_keypad
  import studio2_pkg::*;
#(
  parameter int STRETCH_CYCLES = 700000,
  parameter int STRETCH_W      = 20
) (
  input  logic        clk_sys,
  input  logic        resetq,
  input  logic [10:0] ps2_key,
  input  logic [2:0]  io_n,
  input  logic        io_out,
  input  logic [7:0]  io_dout,
  output logic        ef3_n,
  output logic        ef4_n,
  output logic [3:0]  key_sel,
  output keymask_t    kp1_keys,
  output keymask_t    kp2_keys
);

  logic     tog_q;
  logic     armed;
  logic     io_out_q;
  logic     key_evt;
  logic     sel_wr;
  logic     kp1_vld;
  logic     kp2_vld;
  key_hit_t kp1_hit;
  key_hit_t kp2_hit;
  logic     unused_dout;

  // The first clock after reset just captures the toggle level, so a held toggle is not an event.
  assign key_evt = armed && (ps2_key[10] != tog_q);
  assign sel_wr  = io_out && !io_out_q && (io_n == KEYSEL_PORT);

  assign kp1_hit = lookup_code(ps2_key[7:0], KP1_CODES);
  assign kp2_hit = lookup_code(ps2_key[7:0], KP2_CODES);
  assign kp1_vld = !ps2_key[8] && kp1_hit.valid;
  assign kp2_vld = !ps2_key[8] && kp2_hit.valid;

  assign unused_dout = ^io_dout[7:4];

  always_ff @(posedge clk_sys or negedge resetq) begin
    if (!resetq) begin
      tog_q    <= 1'b0;
      armed    <= 1'b0;
      io_out_q <= 1'b0;
      key_sel  <= 4'hF;
      ef3_n    <= 1'b1;
      ef4_n    <= 1'b1;
    end else begin
      tog_q    <= ps2_key[10];
      armed    <= 1'b1;
      io_out_q <= io_out;
      if (sel_wr) key_sel <= io_dout[3:0];
      ef3_n    <= ~key_selected(kp1_keys, key_sel);
      ef4_n    <= ~key_selected(kp2_keys, key_sel);
    end
  end

  studio2_keybank #(
    .STRETCH_CYCLES (STRETCH_CYCLES),
    .STRETCH_W      (STRETCH_W)
  ) u_kp1 (
    .clk_sys   (clk_sys),
    .resetq    (resetq),
    .key_evt   (key_evt),
    .key_press (ps2_key[9]),
    .idx_vld   (kp1_vld),
    .key_idx   (kp1_hit.idx),
    .keys      (kp1_keys)
  );

  studio2_keybank #(
    .STRETCH_CYCLES (STRETCH_CYCLES),
    .STRETCH_W      (STRETCH_W)
  ) u_kp2 (
    .clk_sys   (clk_sys),
    .resetq    (resetq),
    .key_evt   (key_evt),
    .key_press (ps2_key[9]),
    .idx_vld   (kp2_vld),
    .key_idx   (kp2_hit.idx),
    .keys      (kp2_keys)
  );

endmodule

// File: tb/tb_studio2_keypad.sv
// tb/tb_studio2_keypad.sv - Scoreboard bench for studio2_keypad; covers the STUDIO2_KEY_STRETCH_EN hold when defined
module tb_studio2_keypad;

  localparam int STRETCH = 10;

  logic        clk_sys = 1'b0;
  logic        resetq;
  logic [10:0] ps2_key;
  logic [2:0]  io_n;
  logic        io_out;
  logic [7:0]  io_dout;
  logic        ef3_n;
  logic        ef4_n;
  logic [3:0]  key_sel;
  logic [9:0]  kp1_keys;
  logic [9:0]  kp2_keys;

  studio2_keypad #(
    .STRETCH_CYCLES (STRETCH),
    .STRETCH_W      (8)
  ) dut (
    .clk_sys  (clk_sys),
    .resetq   (resetq),
    .ps2_key  (ps2_key),
    .io_n     (io_n),
    .io_out   (io_out),
    .io_dout  (io_dout),
    .ef3_n    (ef3_n),
    .ef4_n    (ef4_n),
    .key_sel  (key_sel),
    .kp1_keys (kp1_keys),
    .kp2_keys (kp2_keys)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic [7:0] kp1_tbl [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] kp2_tbl [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    logic [9:0] kp1;
    logic [9:0] kp2;
    logic [3:0] sel;
    logic       ef3;
    logic       ef4;
  } exp_t;

  exp_t  sb_q [$];
  string tag_q [$];

  always @(negedge clk_sys) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      if (e.due < cyc) begin
        check_eq({t, "_late"}, cyc, e.due);
      end else begin
        check_eq({t, "_kp1"}, 32'(kp1_keys), 32'(e.kp1));
        check_eq({t, "_kp2"}, 32'(kp2_keys), 32'(e.kp2));
        check_eq({t, "_sel"}, 32'(key_sel), 32'(e.sel));
        check_eq({t, "_ef3"}, 32'(ef3_n), 32'(e.ef3));
        check_eq({t, "_ef4"}, 32'(ef4_n), 32'(e.ef4));
      end
    end
  end

  // Reference state: raw masks, per-pad hold key (-1 = none), select latch.
  logic [9:0] m_raw1, m_raw2;
  int         m_hold1 = -1, m_hold2 = -1;
  int         hold_c  = 0;
  logic [3:0] m_sel;

  function automatic logic [9:0] eff(input logic [9:0] raw, input int hold);
    logic [9:0] r;
    r = raw;
    if (hold >= 0) r[hold] = 1'b1;
    return r;
  endfunction

  function automatic logic ef_of(input logic [9:0] m, input logic [3:0] s);
    return !(s < 4'd10 && m[s]);
  endfunction

  task automatic push(input int due, input string tag, input logic [9:0] k1, input logic [9:0] k2,
                      input logic [3:0] s, input logic e3, input logic e4);
    exp_t e;
    e.due = due; e.kp1 = k1; e.kp2 = k2; e.sel = s; e.ef3 = e3; e.ef4 = e4;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic apply(inout logic [9:0] raw, inout int hold, input int idx, input bit press);
`ifdef STUDIO2_KEY_STRETCH_EN
    if (!press && raw[idx]) hold = idx;
    else if (press && hold == idx) hold = -1;
`endif
    raw[idx] = press;
  endtask

  task automatic act(input string tag, input bit do_key, input bit press, input bit ext,
                     input logic [7:0] code, input bit do_sel, input logic [2:0] n,
                     input logic [7:0] dout, input bit wait_hold);
    int         c, i1, i2, hend;
    logic       o3, o4;
    logic [9:0] e1, e2, n1, n2;
    @(posedge clk_sys); #1;
    c  = cyc;
    o3 = ef_of(eff(m_raw1, m_hold1), m_sel);
    o4 = ef_of(eff(m_raw2, m_hold2), m_sel);
    if (do_key) begin
      ps2_key = {~ps2_key[10], press, ext, code};
      i1 = -1; i2 = -1;
      for (int k = 0; k < 10; k++) begin
        if (!ext && code == kp1_tbl[k]) i1 = k;
        if (!ext && code == kp2_tbl[k]) i2 = k;
      end
      if (i1 >= 0) apply(m_raw1, m_hold1, i1, press);
      if (i2 >= 0) apply(m_raw2, m_hold2, i2, press);
      if (!press && (i1 >= 0 || i2 >= 0)) hold_c = c;
    end
    if (do_sel) begin
      io_n = n; io_dout = dout; io_out = 1'b1;
      if (n == 3'd2) m_sel = dout[3:0];
    end
    e1 = eff(m_raw1, m_hold1);
    e2 = eff(m_raw2, m_hold2);
    push(c + 1, {tag, "_a"}, e1, e2, m_sel, o3, o4);
    push(c + 2, tag, e1, e2, m_sel, ef_of(e1, m_sel), ef_of(e2, m_sel));
    @(posedge clk_sys); #1;
    io_out = 1'b0;
    @(posedge clk_sys); #1;
    if (wait_hold && (m_hold1 >= 0 || m_hold2 >= 0)) begin
      hend = hold_c + STRETCH;
      push(hend, {tag, "_hold"}, e1, e2, m_sel, ef_of(e1, m_sel), ef_of(e2, m_sel));
      m_hold1 = -1; m_hold2 = -1;
      n1 = m_raw1; n2 = m_raw2;
      push(hend + 1, {tag, "_drop"}, n1, n2, m_sel, ef_of(e1, m_sel), ef_of(e2, m_sel));
      push(hend + 2, {tag, "_efd"}, n1, n2, m_sel, ef_of(n1, m_sel), ef_of(n2, m_sel));
      while (cyc < hend + 2) begin
        @(posedge clk_sys); #1;
      end
    end
    @(negedge clk_sys);
  endtask

  task automatic key(input string tag, input bit press, input bit ext, input logic [7:0] code,
                     input bit wait_hold);
    act(tag, 1'b1, press, ext, code, 1'b0, 3'd0, 8'h00, wait_hold);
  endtask

  task automatic sel(input string tag, input logic [2:0] n, input logic [7:0] dout);
    act(tag, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, n, dout, 1'b1);
  endtask

  task automatic idle(input string tag);
    act(tag, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetq = 1'b0; ps2_key = 11'h400; io_n = 3'd0; io_out = 1'b0; io_dout = 8'h00;
    m_raw1 = '0; m_raw2 = '0; m_sel = 4'hF;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_eq("rst_kp1", 32'(kp1_keys), 32'h0);
    check_eq("rst_kp2", 32'(kp2_keys), 32'h0);
    check_eq("rst_sel", 32'(key_sel), 32'hF);
    check_eq("rst_ef3", 32'(ef3_n), 32'h1);
    check_eq("rst_ef4", 32'(ef4_n), 32'h1);
    @(posedge clk_sys); #1;
    resetq = 1'b1;
    idle("post_rst");

    key("p2E", 1, 0, 8'h2E, 1);
    sel("sel5", 3'd2, 8'h05);
    key("p75", 1, 0, 8'h75, 1);
    sel("sel8", 3'd2, 8'h08);
    key("ext75", 0, 1, 8'h75, 1);
    key("unmap1C", 1, 0, 8'h1C, 1);
    key("typ2E", 1, 0, 8'h2E, 1);
    key("rel70_up", 0, 0, 8'h70, 1);
    key("p7D", 1, 0, 8'h7D, 1);
    sel("sel9", 3'd2, 8'h09);
    key("r7D", 0, 0, 8'h7D, 1);
    key("p45", 1, 0, 8'h45, 1);
    sel("sel0", 3'd2, 8'h00);
    key("r45", 0, 0, 8'h45, 1);
    sel("sel8b", 3'd2, 8'h08);
    key("r75", 0, 0, 8'h75, 1);

    key("p26", 1, 0, 8'h26, 1);
    sel("sel3", 3'd2, 8'h03);
    sel("selC", 3'd2, 8'h0C);
    sel("selport3", 3'd3, 8'h03);
    sel("sel3b", 3'd2, 8'h03);
    act("r26_sel5", 1'b1, 1'b0, 1'b0, 8'h26, 1'b1, 3'd2, 8'h05, 1'b1);
    key("r2E", 0, 0, 8'h2E, 1);

    key("p16", 1, 0, 8'h16, 1);
    key("p1E", 1, 0, 8'h1E, 1);
    sel("sel1", 3'd2, 8'h01);
    key("r16", 0, 0, 8'h16, 0);
    key("r1E", 0, 0, 8'h1E, 1);

    key("p16b", 1, 0, 8'h16, 1);
    key("r16b", 0, 0, 8'h16, 0);
    @(posedge clk_sys); #1;
    resetq = 1'b0;
    #1;
    check_eq("arst_kp1", 32'(kp1_keys), 32'h0);
    check_eq("arst_ef3", 32'(ef3_n), 32'h1);
    check_eq("arst_sel", 32'(key_sel), 32'hF);
    m_raw1 = '0; m_raw2 = '0; m_hold1 = -1; m_hold2 = -1; m_sel = 4'hF;
    repeat (2) @(posedge clk_sys);
    #1;
    resetq = 1'b1;
    repeat (STRETCH + 2) @(posedge clk_sys);
    idle("post_arst");
    sel("sel1c", 3'd2, 8'h01);

    repeat (3) @(posedge clk_sys);
    check_eq("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
